move_ctrl: RTL and testbench

Turn and move sequencer for the Connect Four game. It consumes the one-cycle enable pulses from three button debouncers (left, right, drop) and maintains the cursor column and the per-column fill heights. It schedules each accepted drop as a write to the board memory, then as a request to the win checker, and alternates the two players until a win or a draw. It sits between the debouncer instances and the board/checker datapath, and it is the only writer of the board.

---
 rtl/connect4_pkg.sv | 28 ++
 rtl/col_height_file.sv | 50 +++++
 rtl/move_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_move_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : connect4_pkg                                            |
// | Brief    : Shared board dimensions, player and FSM state types     |
// |            for the Connect Four move sequencer.                    |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package connect4_pkg;

  localparam int N_COLS = 7;
  localparam int N_ROWS = 6;
  localparam int CW     = 3;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    READY = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/col_height_file.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : col_height_file                                         |
// | Brief    : Per-column fill heights. One combinational read port,   |
// |            one increment port and a synchronous clear.             |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module col_height_file
  import connect4_pkg::*;
#(
  parameter int N_COLS = connect4_pkg::N_COLS,
  parameter int CW     = connect4_pkg::CW
) (
  input  logic          CLK,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic [CW-1:0] i_inc_col,
  input  logic [CW-1:0] i_rd_col,
  output logic [CW-1:0] o_rd_height
);

  logic [CW-1:0] w_heights [N_COLS];

  for (genvar g = 0; g < N_COLS; g++) begin : g_col
    logic [CW-1:0] r_height;

    // Clear has priority so a restart never races a pending increment
    always_ff @(posedge CLK) begin
      if (i_clr) begin
        r_height <= '0;
      end else if (i_inc && (i_inc_col == CW'(g))) begin
        r_height <= r_height + 1'b1;
      end
    end

    assign w_heights[g] = r_height;
  end

  // Read mux; columns outside the board read as zero
  always_comb begin
    o_rd_height = '0;
    for (int i = 0; i < N_COLS; i++) begin
      if (i_rd_col == CW'(i)) begin
        o_rd_height = w_heights[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : move_ctrl                                               |
// | Brief    : Connect Four turn/move sequencer. Tracks the cursor,    |
// |            schedules board writes and win checks, alternates the   |
// |            players and detects game end.                           |
// | Config   : CURSOR_WRAP_EN - cursor wraps at the board edges        |
// |            instead of saturating.                                  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module move_ctrl
  import connect4_pkg::*;
#(
  parameter int N_COLS = connect4_pkg::N_COLS,
  parameter int N_ROWS = connect4_pkg::N_ROWS,
  parameter int CW     = connect4_pkg::CW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          L_SCEN,
  input  logic          L_MCEN,
  input  logic          R_SCEN,
  input  logic          R_MCEN,
  input  logic          D_SCEN,
  input  logic          NEW_GAME,
  input  logic          WR_ACK,
  input  logic          CHK_DONE,
  input  logic          CHK_WIN,
  output logic [CW-1:0] CURSOR,
  output logic          PLAYER,
  output logic          WR_REQ,
  output logic [CW-1:0] WR_COL,
  output logic [CW-1:0] WR_ROW,
  output logic          WR_PLAYER,
  output logic          CHK_REQ,
  output logic          ILLEGAL,
  output logic          GAME_OVER,
  output logic          WINNER,
  output logic          DRAW
);

  localparam int c_CELLS = N_COLS * N_ROWS;
  localparam int c_MW    = $clog2(c_CELLS + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cursor;
  player_t         r_player;
  logic [c_MW-1:0] r_moves;
  logic            r_wr_req;
  logic [CW-1:0]   r_wr_col;
  logic [CW-1:0]   r_wr_row;
  player_t         r_wr_player;
  logic            r_chk_req;
  logic            r_illegal;
  logic            r_game_over;
  logic            r_winner;
  logic            r_draw;

  logic            w_mv_l;
  logic            w_mv_r;
  logic [CW-1:0]   w_cur_dec;
  logic [CW-1:0]   w_cur_inc;
  logic [CW-1:0]   w_height;
  logic            w_new_game;
  logic            w_inc;

  assign w_mv_l     = L_SCEN | L_MCEN;
  assign w_mv_r     = R_SCEN | R_MCEN;
  assign w_new_game = (r_state == OVER) && NEW_GAME;
  assign w_inc      = (r_state == WRITE) && WR_ACK;

`ifdef CURSOR_WRAP_EN
  assign w_cur_dec = (r_cursor == '0) ? CW'(N_COLS - 1) : r_cursor - 1'b1;
  assign w_cur_inc = (r_cursor == CW'(N_COLS - 1)) ? '0 : r_cursor + 1'b1;
`else
  assign w_cur_dec = (r_cursor == '0) ? r_cursor : r_cursor - 1'b1;
  assign w_cur_inc = (r_cursor == CW'(N_COLS - 1)) ? r_cursor : r_cursor + 1'b1;
`endif

  col_height_file #(
    .N_COLS (N_COLS),
    .CW     (CW)
  ) u_heights (
    .CLK         (CLK),
    .i_clr       (RESET | w_new_game),
    .i_inc       (w_inc),
    .i_inc_col   (r_wr_col),
    .i_rd_col    (r_cursor),
    .o_rd_height (w_height)
  );

  // Sequencer FSM with registered outputs, cursor and move counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= READY;
      r_cursor    <= '0;
      r_player    <= P1;
      r_moves     <= '0;
      r_wr_req    <= 1'b0;
      r_wr_col    <= '0;
      r_wr_row    <= '0;
      r_wr_player <= P1;
      r_chk_req   <= 1'b0;
      r_illegal   <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_draw      <= 1'b0;
    end else begin
      r_chk_req <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        READY: begin
          // A drop wins over any same-cycle cursor movement
          if (D_SCEN) begin
            if (w_height < CW'(N_ROWS)) begin
              r_wr_req    <= 1'b1;
              r_wr_col    <= r_cursor;
              r_wr_row    <= w_height;
              r_wr_player <= r_player;
              r_state     <= WRITE;
            end else begin
              r_illegal <= 1'b1;
            end
          end else if (w_mv_l && !w_mv_r) begin
            r_cursor <= w_cur_dec;
          end else if (w_mv_r && !w_mv_l) begin
            r_cursor <= w_cur_inc;
          end
        end
        WRITE: begin
          if (WR_ACK) begin
            r_wr_req  <= 1'b0;
            r_moves   <= r_moves + 1'b1;
            r_chk_req <= 1'b1;
            r_state   <= CHECK;
          end
        end
        CHECK: begin
          // A done pulse coincident with our own start pulse is stale
          if (CHK_DONE && !r_chk_req) begin
            if (CHK_WIN) begin
              r_game_over <= 1'b1;
              r_winner    <= r_wr_player;
              r_state     <= OVER;
            end else if (r_moves == c_MW'(c_CELLS)) begin
              r_game_over <= 1'b1;
              r_draw      <= 1'b1;
              r_state     <= OVER;
            end else begin
              r_player <= (r_player == P1) ? P2 : P1;
              r_state  <= READY;
            end
          end
        end
        OVER: begin
          if (NEW_GAME) begin
            r_cursor    <= '0;
            r_player    <= P1;
            r_moves     <= '0;
            r_wr_col    <= '0;
            r_wr_row    <= '0;
            r_wr_player <= P1;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_draw      <= 1'b0;
            r_state     <= READY;
          end
        end
        default: r_state <= READY;
      endcase
    end
  end

  assign CURSOR    = r_cursor;
  assign PLAYER    = r_player;
  assign WR_REQ    = r_wr_req;
  assign WR_COL    = r_wr_col;
  assign WR_ROW    = r_wr_row;
  assign WR_PLAYER = r_wr_player;
  assign CHK_REQ   = r_chk_req;
  assign ILLEGAL   = r_illegal;
  assign GAME_OVER = r_game_over;
  assign WINNER    = r_winner;
  assign DRAW      = r_draw;

endmodule
`default_nettype wire

// File: tb/tb_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_move_ctrl                                            |
// | Brief    : Self-checking bench for move_ctrl against a game-level  |
// |            reference model (cursor, heights, turn, outcome).       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_move_ctrl;

  localparam int NC = 7;
  localparam int NR = 6;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       L_SCEN = 1'b0, L_MCEN = 1'b0, R_SCEN = 1'b0, R_MCEN = 1'b0;
  logic       D_SCEN = 1'b0, NEW_GAME = 1'b0, WR_ACK = 1'b0;
  logic       CHK_DONE = 1'b0, CHK_WIN = 1'b0;
  logic [2:0] CURSOR, WR_COL, WR_ROW;
  logic       PLAYER, WR_REQ, WR_PLAYER, CHK_REQ, ILLEGAL;
  logic       GAME_OVER, WINNER, DRAW;

  move_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .L_SCEN(L_SCEN), .L_MCEN(L_MCEN), .R_SCEN(R_SCEN), .R_MCEN(R_MCEN),
    .D_SCEN(D_SCEN), .NEW_GAME(NEW_GAME), .WR_ACK(WR_ACK),
    .CHK_DONE(CHK_DONE), .CHK_WIN(CHK_WIN),
    .CURSOR(CURSOR), .PLAYER(PLAYER), .WR_REQ(WR_REQ), .WR_COL(WR_COL),
    .WR_ROW(WR_ROW), .WR_PLAYER(WR_PLAYER), .CHK_REQ(CHK_REQ),
    .ILLEGAL(ILLEGAL), .GAME_OVER(GAME_OVER), .WINNER(WINNER), .DRAW(DRAW)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Game-level reference model
  int m_cur, m_player, m_moves, m_over, m_draw, m_winner;
  int m_wc, m_wr, m_wp;
  int m_h [NC];

  task automatic m_reset();
    m_cur = 0; m_player = 0; m_moves = 0; m_over = 0; m_draw = 0;
    m_winner = 0; m_wc = 0; m_wr = 0; m_wp = 0;
    for (int i = 0; i < NC; i++) m_h[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cursor"}, 32'(CURSOR), 32'(m_cur));
    chk({tag, ".player"}, 32'(PLAYER), 32'(m_player));
    chk({tag, ".wr_req"}, 32'(WR_REQ), 0);
    chk({tag, ".wr_col"}, 32'(WR_COL), 32'(m_wc));
    chk({tag, ".wr_row"}, 32'(WR_ROW), 32'(m_wr));
    chk({tag, ".wr_player"}, 32'(WR_PLAYER), 32'(m_wp));
    chk({tag, ".chk_req"}, 32'(CHK_REQ), 0);
    chk({tag, ".illegal"}, 32'(ILLEGAL), 0);
    chk({tag, ".game_over"}, 32'(GAME_OVER), 32'(m_over));
    chk({tag, ".winner"}, 32'(WINNER), 32'(m_winner));
    chk({tag, ".draw"}, 32'(DRAW), 32'(m_draw));
  endtask

  task automatic do_move(input bit ls, input bit lm, input bit rs, input bit rm);
    bit ml, mr;
    ml = ls | lm;
    mr = rs | rm;
    L_SCEN = ls; L_MCEN = lm; R_SCEN = rs; R_MCEN = rm;
    tick();
    L_SCEN = 0; L_MCEN = 0; R_SCEN = 0; R_MCEN = 0;
    if (!m_over) begin
      if (ml && !mr) begin
`ifdef CURSOR_WRAP_EN
        m_cur = (m_cur == 0) ? NC - 1 : m_cur - 1;
`else
        m_cur = (m_cur == 0) ? 0 : m_cur - 1;
`endif
      end else if (mr && !ml) begin
`ifdef CURSOR_WRAP_EN
        m_cur = (m_cur == NC - 1) ? 0 : m_cur + 1;
`else
        m_cur = (m_cur == NC - 1) ? NC - 1 : m_cur + 1;
`endif
      end
    end
    chk("move.cursor", 32'(CURSOR), 32'(m_cur));
  endtask

  task automatic goto_col(input int c);
    while (m_cur < c) do_move(0, 0, 1, 0);
    while (m_cur > c) do_move(1, 0, 0, 0);
  endtask

  task automatic goto_free();
    for (int c = 0; c < NC; c++) begin
      if (m_h[c] < NR) begin
        goto_col(c);
        return;
      end
    end
  endtask

  // One drop attempt; dly = number of cycles WR_REQ is held before ACK
  task automatic do_drop(input int dly, input bit win);
    if (m_over) begin
      D_SCEN = 1; tick(); D_SCEN = 0;
      chk("over_drop.wr_req", 32'(WR_REQ), 0);
      chk("over_drop.illegal", 32'(ILLEGAL), 0);
      return;
    end
    if (m_h[m_cur] == NR) begin
      D_SCEN = 1; tick(); D_SCEN = 0;
      chk("full.illegal", 32'(ILLEGAL), 1);
      chk("full.wr_req", 32'(WR_REQ), 0);
      tick();
      chk("full.illegal_pulse", 32'(ILLEGAL), 0);
      chk("full.wr_req2", 32'(WR_REQ), 0);
      chk("full.player", 32'(PLAYER), 32'(m_player));
      return;
    end
    m_wc = m_cur; m_wr = m_h[m_cur]; m_wp = m_player;
    D_SCEN = 1; tick(); D_SCEN = 0;
    chk("drop.wr_req", 32'(WR_REQ), 1);
    chk("drop.wr_col", 32'(WR_COL), 32'(m_wc));
    chk("drop.wr_row", 32'(WR_ROW), 32'(m_wr));
    chk("drop.wr_player", 32'(WR_PLAYER), 32'(m_wp));
    for (int k = 1; k < dly; k++) begin
      L_SCEN = 1'($urandom_range(0, 1));
      tick();
      L_SCEN = 0;
      chk("wait.wr_req", 32'(WR_REQ), 1);
      chk("wait.wr_row", 32'(WR_ROW), 32'(m_wr));
      chk("wait.cursor", 32'(CURSOR), 32'(m_cur));
    end
    WR_ACK = 1; tick(); WR_ACK = 0;
    m_h[m_wc]++;
    m_moves++;
    chk("ack.wr_req", 32'(WR_REQ), 0);
    chk("ack.chk_req", 32'(CHK_REQ), 1);
    // Done coincident with the start pulse must be ignored
    CHK_DONE = 1; CHK_WIN = win; R_SCEN = 1;
    tick();
    CHK_DONE = 0; R_SCEN = 0;
    chk("stale_done.chk_req", 32'(CHK_REQ), 0);
    chk("stale_done.over", 32'(GAME_OVER), 0);
    chk("stale_done.player", 32'(PLAYER), 32'(m_player));
    chk("stale_done.cursor", 32'(CURSOR), 32'(m_cur));
    repeat ($urandom_range(0, 2)) tick();
    CHK_DONE = 1; CHK_WIN = win; tick(); CHK_DONE = 0; CHK_WIN = 0;
    if (win) begin
      m_over = 1; m_winner = m_wp;
    end else if (m_moves == NC * NR) begin
      m_over = 1; m_draw = 1;
    end else begin
      m_player ^= 1;
    end
    check_all("done");
  endtask

  task automatic do_new_game();
    NEW_GAME = 1; tick(); NEW_GAME = 0;
    if (m_over) m_reset();
    check_all("new_game");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    m_reset();
    // Reset
    RESET = 1; tick(); tick(); RESET = 0;
    check_all("reset");

    // Cursor walk and simultaneous left/right
    do_move(0, 0, 1, 0); do_move(0, 0, 1, 0); do_move(0, 0, 1, 0);
    do_move(0, 1, 0, 0);
    chk("walk.cursor", 32'(CURSOR), 2);
    do_move(1, 0, 1, 0);
    chk("both.cursor", 32'(CURSOR), 2);

    // Left edge
    goto_col(0);
    do_move(1, 0, 0, 0);

    // Drop at column 3 with a 4-cycle ACK delay
    goto_col(3);
    do_drop(4, 0);
    chk("drop3.player", 32'(PLAYER), 1);

    // Fill column 0, then one rejected drop
    goto_col(0);
    repeat (NR) do_drop($urandom_range(1, 3), 0);
    do_drop(1, 0);

    // Right edge
    goto_col(NC - 1);
    do_move(0, 0, 0, 1);

    // Randomized play
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0)
        do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (m_moves < 28)
        do_drop($urandom_range(1, 4), 0);
    end

    // NEW_GAME outside OVER is ignored
    do_new_game();

    // P2 wins
    if (m_player == 0) begin
      goto_free();
      do_drop(2, 0);
    end
    goto_free();
    do_drop(1, 1);
    chk("win.winner", 32'(WINNER), 1);
    do_move(0, 0, 1, 0);
    do_move(1, 0, 0, 0);
    do_drop(1, 0);
    do_new_game();

    // Draw: fill every cell
    for (int c = 0; c < NC; c++) begin
      goto_col(c);
      repeat (NR) do_drop($urandom_range(1, 3), 0);
    end
    chk("draw.draw", 32'(DRAW), 1);
    chk("draw.over", 32'(GAME_OVER), 1);
    do_new_game();

    // Reset while a write is outstanding
    goto_col(2);
    D_SCEN = 1; tick(); D_SCEN = 0;
    chk("rst.wr_req_before", 32'(WR_REQ), 1);
    RESET = 1; tick(); RESET = 0;
    m_reset();
    chk("rst.wr_req_after", 32'(WR_REQ), 0);
    check_all("rst");
    do_drop(1, 0);
    chk("rst.row_after", 32'(WR_ROW), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
